cas_audio_mixer: RTL and testbench

//  Downstream audio stage between coco3fpga SOUND_LEFT and AUDIO_L. Replaces the single-bit XOR of

---
 rtl/cas_audio_mixer.sv | 162 ++++++++++++++++
 tb/tb_cas_audio_mixer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/cas_audio_mixer.sv
// Tape-monitor audio mixer: casdout square tone with click-free gain ramps, summed into the CoCo sound word.
// Optional build macro CAS_AUDIO_LPF_EN adds a one-pole low-pass on the tone path.
`timescale 1ns/1ps

module cas_audio_mixer #(
    parameter int          CLK_DIV  = 1193,
    parameter logic [15:0] TAPE_AMP = 16'h0800
`ifdef CAS_AUDIO_LPF_EN
    ,
    parameter int          LPF_SHIFT = 2
`endif
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [15:0] sound_in,
    input  logic        casdout,
    input  logic        cas_relay,
    input  logic        monitor_en,
    output logic [15:0] audio_out,
    output logic        sample_stb
);

    // state    | meaning
    // IDLE     | gain 0, tape muted
    // FADE_IN  | gain ramping up one step per sample
    // ON       | gain 255, full tape level
    // FADE_OUT | gain ramping down one step per sample
    typedef enum logic [1:0] {IDLE, FADE_IN, ON, FADE_OUT} state_t;

    localparam int                CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0]   r_cnt;
    logic               r_tape_meta;
    logic               r_tape_s;
    state_t             r_state;
    state_t             w_state_nxt;
    logic [7:0]         r_gain;
    logic [7:0]         w_gain_nxt;
    logic               w_stb;
    logic               w_target;
    logic signed [17:0] w_tone;
    logic signed [26:0] w_prod;
    logic signed [17:0] w_t;
    logic signed [17:0] w_mix;
    logic signed [17:0] w_sum;
    logic [15:0]        w_sat;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_stb      = (r_cnt == CNT_LAST);
    assign sample_stb = w_stb;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_tape_meta <= 1'b0;
            r_tape_s    <= 1'b0;
        end else begin
            r_tape_meta <= casdout;
            r_tape_s    <= r_tape_meta;
        end
    end

    assign w_target = monitor_en & cas_relay;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state <= IDLE;
            r_gain  <= 8'd0;
        end else if (w_stb) begin
            r_state <= w_state_nxt;
            r_gain  <= w_gain_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:     w_state_nxt = w_target ? FADE_IN : IDLE;
            ON:       w_state_nxt = w_target ? ON : FADE_OUT;
            FADE_IN,
            FADE_OUT: begin
                if (w_target) begin
                    w_state_nxt = (r_gain >= 8'd254) ? ON : FADE_IN;
                end else begin
                    w_state_nxt = (r_gain <= 8'd1) ? IDLE : FADE_OUT;
                end
            end
            default:  w_state_nxt = IDLE;
        endcase
    end

    // Gain always steps toward the target and saturates at both ends.
    always_comb begin
        w_gain_nxt = r_gain;
        case (r_state)
            IDLE:     w_gain_nxt = w_target ? 8'd1 : 8'd0;
            ON:       w_gain_nxt = w_target ? 8'd255 : 8'd254;
            FADE_IN,
            FADE_OUT: begin
                if (w_target) begin
                    w_gain_nxt = (r_gain == 8'd255) ? 8'd255 : r_gain + 8'd1;
                end else begin
                    w_gain_nxt = (r_gain == 8'd0) ? 8'd0 : r_gain - 8'd1;
                end
            end
            default:  w_gain_nxt = 8'd0;
        endcase
    end

    assign w_tone = r_tape_s ? $signed({2'b00, TAPE_AMP}) : -$signed({2'b00, TAPE_AMP});
    assign w_prod = w_tone * $signed({1'b0, r_gain});
    assign w_t    = 18'(w_prod >>> 8);

`ifdef CAS_AUDIO_LPF_EN
    logic signed [17:0] r_y;
    logic signed [17:0] w_diff;
    logic signed [17:0] w_y_nxt;

    assign w_diff  = w_t - r_y;
    assign w_y_nxt = r_y + (w_diff >>> LPF_SHIFT);
    assign w_mix   = w_y_nxt;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_y <= '0;
        end else if (w_stb) begin
            r_y <= w_y_nxt;
        end
    end
`else
    assign w_mix = w_t;
`endif

    assign w_sum = $signed({2'b00, sound_in}) + w_mix;

    always_comb begin
        w_sat = w_sum[15:0];
        if (w_sum[17]) begin
            w_sat = 16'h0000;
        end else if (w_sum[16]) begin
            w_sat = 16'hFFFF;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            audio_out <= 16'h0000;
        end else if (w_stb) begin
            audio_out <= w_sat;
        end
    end

endmodule

// File: tb/tb_cas_audio_mixer.sv
// Directed bench for cas_audio_mixer with CLK_DIV=4: strobe timing, gain ramps, saturation, reset.
`timescale 1ns/1ps

module tb_cas_audio_mixer;

    localparam int DIV = 4;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [15:0] sound_in;
    logic        casdout;
    logic        cas_relay;
    logic        monitor_en;
    logic [15:0] audio_out;
    logic        sample_stb;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [15:0] sound;
        logic        cas;
        logic        relay;
        logic        mon;
        logic        toggle;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [8];

    cas_audio_mixer #(
        .CLK_DIV  (DIV),
        .TAPE_AMP (16'h0800)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .sound_in   (sound_in),
        .casdout    (casdout),
        .cas_relay  (cas_relay),
        .monitor_en (monitor_en),
        .audio_out  (audio_out),
        .sample_stb (sample_stb)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Waits for the next strobe, then returns #1 after the edge that ends it.
    task automatic wait_stb(input bit toggle);
        bit found = 1'b0;
        for (int i = 0; i < 3 * DIV && !found; i++) begin
            @(negedge clk_sys);
            if (sample_stb) found = 1'b1;
            else if (toggle) casdout = ~casdout;
        end
        if (!found) begin
            n_cmp++;
            n_bad++;
            $display("FAIL stb_timeout: got no strobe expected one within %0d cycles", 3 * DIV);
        end
        @(posedge clk_sys);
        #1;
    endtask

    task automatic apply_vec(input int idx);
        sound_in   = vecs[idx].sound;
        casdout    = vecs[idx].cas;
        cas_relay  = vecs[idx].relay;
        monitor_en = vecs[idx].mon;
        wait_stb(vecs[idx].toggle);
        check($sformatf("vec%0d", idx), audio_out, vecs[idx].exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int k;
        int g;

        // gain 0: output must be sound_in whatever casdout does
        vecs[0] = '{16'h1234, 1'b1, 1'b1, 1'b0, 1'b1, 16'h1234};
        vecs[1] = '{16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000};
        vecs[2] = '{16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b1, 16'hFFFF};
        vecs[3] = '{16'h8000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h8000};
        // gain 255: tone +/-0x7F8 with saturation
        vecs[4] = '{16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b0, 16'hFFFF};
        vecs[5] = '{16'h0100, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000};
        vecs[6] = '{16'h0800, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0008};
        vecs[7] = '{16'h1000, 1'b1, 1'b1, 1'b1, 1'b0, 16'h17F8};

        reset = 1'b1; sound_in = 16'h0; casdout = 1'b0; cas_relay = 1'b0; monitor_en = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1;
        reset = 1'b0;

        for (int c = 1; c <= 12; c++) begin
            @(negedge clk_sys);
            check($sformatf("stb_cycle%0d", c), {15'b0, sample_stb}, {15'b0, (c % DIV) == 0});
            check($sformatf("out_idle%0d", c), audio_out, 16'h0000);
        end
        @(posedge clk_sys);
        #1;

        for (int i = 0; i < 4; i++) apply_vec(i);

        // fade in from gain 0 with casdout high
        sound_in = 16'h8000; casdout = 1'b1; cas_relay = 1'b1; monitor_en = 1'b1;
        for (int s = 1; s <= 260; s++) begin
            wait_stb(1'b0);
            g = (s - 1 > 255) ? 255 : s - 1;
            check($sformatf("fade_in%0d", s), audio_out, 16'h8000 + 16'(8 * g));
        end

        for (int i = 4; i < 8; i++) apply_vec(i);

        // fade out from ON down to gain 100
        sound_in = 16'h8000; casdout = 1'b1; cas_relay = 1'b0;
        for (int s = 1; s <= 155; s++) begin
            wait_stb(1'b0);
            check($sformatf("fade_out%0d", s), audio_out, 16'h8000 + 16'(8 * (256 - s)));
        end

        cas_relay = 1'b1;
        wait_stb(1'b0);
        check("reraise_g100", audio_out, 16'h8320);
        wait_stb(1'b0);
        check("reraise_g101", audio_out, 16'h8328);

        cas_relay = 1'b0;
        for (int s = 1; s <= 110; s++) begin
            wait_stb(1'b0);
            g = (103 - s < 0) ? 0 : 103 - s;
            check($sformatf("fade_out2_%0d", s), audio_out, 16'h8000 + 16'(8 * g));
        end

        sound_in = 16'h4321; casdout = 1'b0;
        wait_stb(1'b1);
        check("idle_passthru", audio_out, 16'h4321);

        // ramp to gain 128, then reset mid-period
        sound_in = 16'h0000; casdout = 1'b1; cas_relay = 1'b1; monitor_en = 1'b1;
        for (int s = 1; s <= 128; s++) wait_stb(1'b0);
        check("pre_reset_g127", audio_out, 16'h03F8);
        @(posedge clk_sys);
        #1;
        reset = 1'b1;
        @(posedge clk_sys);
        #1;
        check("rst_out", audio_out, 16'h0000);
        check("rst_stb", {15'b0, sample_stb}, 16'h0000);
        reset = 1'b0;
        sound_in = 16'h5555;

        k = 0;
        for (int c = 1; c <= 3 * DIV && k == 0; c++) begin
            @(negedge clk_sys);
            if (sample_stb) k = c;
        end
        check("rst_first_stb", 16'(k), 16'(DIV));
        @(posedge clk_sys);
        #1;
        check("rst_gain0", audio_out, 16'h5555);
        wait_stb(1'b0);
        check("rst_gain1", audio_out, 16'h555D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
